// File: rtl/sprite_painter_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_painter_if
// Description : Memory-side bus of the sprite painter. It carries the
//               sprite-sheet ROM read port and the framebuffer write port.
//               The painter is the master. The ROM/framebuffer side is the
//               slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_painter_if #(
  parameter int ADDR_W = 19
) ();

  logic [ADDR_W-1:0] rom_addr;  // sheet read address, data returns next cycle
  logic              rom_data;  // pixel for the previous cycle's address
  logic              fb_we;     // framebuffer write strobe
  logic [ADDR_W-1:0] fb_addr;   // framebuffer write address, y*FB_W+x
  logic              fb_data;   // framebuffer write pixel

  modport master (
    output rom_addr,
    input  rom_data,
    output fb_we,
    output fb_addr,
    output fb_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  fb_we,
    input  fb_addr,
    input  fb_data
  );

endinterface
`default_nettype wire

// File: rtl/sprite_painter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_painter
// Description : Rasterises a per-frame render list of sprite rectangles into
//               a double-buffered 1-bpp framebuffer. Each frame first clears
//               the back buffer. It then copies each slot's sheet rectangle
//               in slot order, so higher slots are drawn on top. Finally it
//               swaps buffers and raises painter_finished_o.
//               Slot packing:
//                 sprite word = {x, y, w, h}, each COORD_W bits, unsigned.
//                 pos word    = {x, y}, each COORD_W bits, two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_painter #(
  parameter int RENDER_SLOTS = 32,
  parameter int FB_W         = 1280,
  parameter int FB_H         = 300,
  parameter int SHEET_W      = 2448,
  parameter int ADDR_W       = 19,
  parameter int COORD_W      = 12
) (
  input  wire                                     clk,
  input  wire                                     rst,
  input  wire                                     frame_start_i,
  input  wire [RENDER_SLOTS-1:0][4*COORD_W-1:0]   sprite_i,
  input  wire [RENDER_SLOTS-1:0][2*COORD_W-1:0]   pos_i,
  sprite_painter_if.master                        mem,
  output logic                                    fb_sel_o,
  output logic                                    painter_finished_o,
  output logic                                    overrun_o
);

  localparam int SLOT_W    = (RENDER_SLOTS > 1) ? $clog2(RENDER_SLOTS) : 1;
  // Destination x/y counters need headroom for a negative origin plus a
  // full-width sprite, hence two extra bits over the coordinate width.
  localparam int XY_W      = COORD_W + 2;
  localparam int FB_PIXELS = FB_W * FB_H;

  localparam logic [ADDR_W-1:0]      c_clr_last  = ADDR_W'(FB_PIXELS - 1);
  localparam logic [ADDR_W-1:0]      c_sheet_w   = ADDR_W'(SHEET_W);
  localparam logic [ADDR_W-1:0]      c_fb_w      = ADDR_W'(FB_W);
  localparam logic signed [XY_W-1:0] c_fb_w_s    = XY_W'(FB_W);
  localparam logic signed [XY_W-1:0] c_fb_h_s    = XY_W'(FB_H);
  localparam logic [SLOT_W-1:0]      c_last_slot = SLOT_W'(RENDER_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SETUP = 3'd2,
    S_DRAW  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Render-list snapshot, taken only on an accepted frame start
  logic [RENDER_SLOTS-1:0][4*COORD_W-1:0] spr_q;
  logic [RENDER_SLOTS-1:0][2*COORD_W-1:0] pos_q;
  logic                                   capture;

  logic [ADDR_W-1:0]      clr_q, clr_d;          // clear address
  logic [SLOT_W-1:0]      slot_q, slot_d;        // current slot
  logic [COORD_W-1:0]     col_q, col_d;          // c within sprite
  logic [COORD_W-1:0]     row_q, row_d;          // r within sprite
  logic signed [XY_W-1:0] cx_q, cx_d;            // pos.x + c
  logic signed [XY_W-1:0] cy_q, cy_d;            // pos.y + r
  logic [ADDR_W-1:0]      rom_row_q, rom_row_d;  // sheet address of column 0 of row r
  logic [ADDR_W-1:0]      rom_ptr_q, rom_ptr_d;  // sheet address of (r,c)
  logic [ADDR_W-1:0]      dst_row_q, dst_row_d;  // fb address of column 0 of row r (mod 2^ADDR_W)
  logic [ADDR_W-1:0]      dst_ptr_q, dst_ptr_d;  // fb address of (r,c)
  logic                   wr_pend_q, wr_pend_d;  // in-bounds pixel awaiting its ROM data
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   fb_sel_q, fb_sel_d;
  logic                   fin_q, fin_d;
  logic                   ovr_q, ovr_d;

  // Current slot fields
  logic [4*COORD_W-1:0]   cur_spr;
  logic [2*COORD_W-1:0]   cur_pos;
  logic [COORD_W-1:0]     spr_x, spr_y, spr_w, spr_h;
  logic [COORD_W-1:0]     pos_x, pos_y;
  logic signed [XY_W-1:0] pos_x_ext, pos_y_ext;
  logic [ADDR_W-1:0]      rom_base, dst_base;
  logic                   in_bounds, row_end, last_row, last_slot, draw_we;

  assign cur_spr   = spr_q[slot_q];
  assign cur_pos   = pos_q[slot_q];
  assign spr_x     = cur_spr[4*COORD_W-1 -: COORD_W];
  assign spr_y     = cur_spr[3*COORD_W-1 -: COORD_W];
  assign spr_w     = cur_spr[2*COORD_W-1 -: COORD_W];
  assign spr_h     = cur_spr[COORD_W-1:0];
  assign pos_x     = cur_pos[2*COORD_W-1 -: COORD_W];
  assign pos_y     = cur_pos[COORD_W-1:0];
  assign pos_x_ext = XY_W'($signed(pos_x));
  assign pos_y_ext = XY_W'($signed(pos_y));

  // Slot base products, the only multiplies in the design. The destination
  // base may wrap for off-screen origins. Any pixel that is actually written
  // lies inside the buffer, so the modular address is exact for it.
  assign rom_base  = ADDR_W'(spr_y) * c_sheet_w + ADDR_W'(spr_x);
  assign dst_base  = ADDR_W'($signed(pos_y)) * c_fb_w + ADDR_W'($signed(pos_x));

  assign in_bounds = !cx_q[XY_W-1] && (cx_q < c_fb_w_s) &&
                     !cy_q[XY_W-1] && (cy_q < c_fb_h_s);
  assign row_end   = (col_q == spr_w - COORD_W'(1));
  assign last_row  = (row_q == spr_h - COORD_W'(1));
  assign last_slot = (slot_q == c_last_slot);

  // Write stage: the ROM pixel for last cycle's address arrives now
  assign draw_we          = wr_pend_q & mem.rom_data;
  assign mem.rom_addr     = rom_ptr_q;
  assign mem.fb_we        = (state_q == S_CLEAR) | draw_we;
  assign mem.fb_addr      = (state_q == S_CLEAR) ? clr_q : wr_addr_q;
  assign mem.fb_data      = draw_we;
  assign fb_sel_o         = fb_sel_q;
  assign painter_finished_o = fin_q;
  assign overrun_o        = ovr_q;

  // Next-state and datapath update for the frame sequencer
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    clr_d     = clr_q;
    slot_d    = slot_q;
    col_d     = col_q;
    row_d     = row_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    rom_row_d = rom_row_q;
    rom_ptr_d = rom_ptr_q;
    dst_row_d = dst_row_q;
    dst_ptr_d = dst_ptr_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    fb_sel_d  = fb_sel_q;
    fin_d     = fin_q;
    ovr_d     = ovr_q | (frame_start_i & (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          capture = 1'b1;
          fin_d   = 1'b0;
          clr_d   = '0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        clr_d = clr_q + ADDR_W'(1);
        if (clr_q == c_clr_last) begin
          slot_d  = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if ((spr_w == '0) || (spr_h == '0)) begin
          if (last_slot) begin
            state_d = S_DRAIN;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end else begin
          col_d     = '0;
          row_d     = '0;
          cx_d      = pos_x_ext;
          cy_d      = pos_y_ext;
          rom_row_d = rom_base;
          rom_ptr_d = rom_base;
          dst_row_d = dst_base;
          dst_ptr_d = dst_base;
          state_d   = S_DRAW;
        end
      end

      S_DRAW: begin
        wr_pend_d = in_bounds;
        wr_addr_d = dst_ptr_q;
        if (row_end) begin
          col_d     = '0;
          row_d     = row_q + COORD_W'(1);
          cx_d      = pos_x_ext;
          cy_d      = cy_q + XY_W'(1);
          rom_row_d = rom_row_q + c_sheet_w;
          rom_ptr_d = rom_row_q + c_sheet_w;
          dst_row_d = dst_row_q + c_fb_w;
          dst_ptr_d = dst_row_q + c_fb_w;
          if (last_row) begin
            if (last_slot) begin
              state_d = S_DRAIN;
            end else begin
              slot_d  = slot_q + SLOT_W'(1);
              state_d = S_SETUP;
            end
          end
        end else begin
          col_d     = col_q + COORD_W'(1);
          cx_d      = cx_q + XY_W'(1);
          rom_ptr_d = rom_ptr_q + ADDR_W'(1);
          dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        end
      end

      S_DRAIN: begin
        fb_sel_d = ~fb_sel_q;
        fin_d    = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q     <= '0;
      slot_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      rom_row_q <= '0;
      rom_ptr_q <= '0;
      dst_row_q <= '0;
      dst_ptr_q <= '0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      fb_sel_q  <= 1'b0;
      fin_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      clr_q     <= clr_d;
      slot_q    <= slot_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      rom_row_q <= rom_row_d;
      rom_ptr_q <= rom_ptr_d;
      dst_row_q <= dst_row_d;
      dst_ptr_q <= dst_ptr_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      fb_sel_q  <= fb_sel_d;
      fin_q     <= fin_d;
      ovr_q     <= ovr_d;
    end
  end

  // Render-list snapshot on an accepted frame start
  always_ff @(posedge clk) begin
    if (capture) begin
      spr_q <= sprite_i;
      pos_q <= pos_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_painter
// Description : Self-checking bench for sprite_painter on a small 16x8
//               framebuffer with a 16-pixel sheet pitch. A reference painter
//               paints the render list slot by slot and produces the
//               expected write list, ROM reads and final image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_painter;

  localparam int RS   = 32;
  localparam int FBW  = 16;
  localparam int FBH  = 8;
  localparam int SHW  = 16;
  localparam int AW   = 19;
  localparam int CW   = 12;
  localparam int NPIX = FBW * FBH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic [RS-1:0][4*CW-1:0] sprite;
  logic [RS-1:0][2*CW-1:0] pos;
  logic fb_sel, fin, ovr;

  sprite_painter_if #(.ADDR_W(AW)) bus ();

  sprite_painter #(
    .RENDER_SLOTS(RS), .FB_W(FBW), .FB_H(FBH),
    .SHEET_W(SHW), .ADDR_W(AW), .COORD_W(CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_start_i      (frame_start),
    .sprite_i           (sprite),
    .pos_i              (pos),
    .mem                (bus),
    .fb_sel_o           (fb_sel),
    .painter_finished_o (fin),
    .overrun_o          (ovr)
  );

  always #5 clk = ~clk;

  // ---------------- ROM model: one-cycle read latency ----------------
  int rom_mode = 0;   // 0 all ink, 1 checkerboard, 2 random, 3 ink only in sheet rows >= 8
  bit rom_mem[4096];

  function automatic bit rom_pix(int a);
    case (rom_mode)
      0:       return 1'b1;
      1:       return (((a % SHW) + (a / SHW)) % 2) == 0;
      2:       return rom_mem[a % 4096];
      default: return (a / SHW) >= 8;
    endcase
  endfunction

  always @(posedge clk) bus.rom_data <= rom_pix(int'(bus.rom_addr));

  // ---------------- Render list and reference painter ----------------
  typedef struct { int sx; int sy; int sw; int sh; int px; int py; } slot_t;
  slot_t slots[RS];

  int exp_addr[$];
  int exp_rom[$];
  bit model_fb[NPIX];
  bit dut_fb[NPIX];

  task automatic clear_slots();
    for (int i = 0; i < RS; i++) slots[i] = '{0, 0, 0, 0, 0, 0};
  endtask

  task automatic load_slots();
    for (int i = 0; i < RS; i++) begin
      sprite[i] = {CW'(slots[i].sx), CW'(slots[i].sy), CW'(slots[i].sw), CW'(slots[i].sh)};
      pos[i]    = {CW'(slots[i].px), CW'(slots[i].py)};
    end
  endtask

  function automatic int frame_cycles();
    int n = NPIX + 2;
    for (int i = 0; i < RS; i++) n += 1 + slots[i].sw * slots[i].sh;
    return n;
  endfunction

  task automatic build_model();
    exp_addr.delete();
    exp_rom.delete();
    for (int i = 0; i < NPIX; i++) model_fb[i] = 1'b0;
    for (int s = 0; s < RS; s++)
      for (int r = 0; r < slots[s].sh; r++)
        for (int c = 0; c < slots[s].sw; c++) begin
          int x, y, ra;
          x  = slots[s].px + c;
          y  = slots[s].py + r;
          ra = (slots[s].sy + r) * SHW + slots[s].sx + c;
          if (rom_pix(ra) && x >= 0 && x < FBW && y >= 0 && y < FBH) begin
            exp_addr.push_back(y * FBW + x);
            exp_rom.push_back(ra);
            model_fb[y * FBW + x] = 1'b1;
          end
        end
  endtask

  // ---------------- Checking infrastructure ----------------
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int prev_rom = 0;
  bit any_we = 1'b0;
  bit exp_sel = 1'b0;
  int wq_addr[$];
  bit wq_data[$];
  int wq_rom[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and log any framebuffer write together
  // with the ROM address that was issued one cycle earlier.
  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (bus.fb_we === 1'b1) begin
      wq_addr.push_back(int'(bus.fb_addr));
      wq_data.push_back(bus.fb_data);
      wq_rom.push_back(prev_rom);
      any_we = 1'b1;
    end
    prev_rom = int'(bus.rom_addr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    exp_sel = 1'b0;
  endtask

  // Pulse frame_start at the current falling edge (cycle 0) and wait for
  // painter_finished. pulse_rel >= 0 adds an extra frame_start pulse in that
  // cycle of the frame. lat is the cycle where painter_finished is seen.
  task automatic run_frame(input int pulse_rel, output int lat);
    int n0, rel;
    bit got;
    wq_addr.delete(); wq_data.delete(); wq_rom.delete();
    got = 1'b0;
    lat = -1;
    frame_start = 1'b1;
    n0 = ncyc;
    tick();
    frame_start = 1'b0;
    chk("finished_drop", fin, 0);
    for (int k = 0; k < 20000 && !got; k++) begin
      tick();
      rel = ncyc - n0;
      frame_start = (rel == pulse_rel);
      if (fin === 1'b1) begin
        got = 1'b1;
        lat = rel;
      end
    end
    frame_start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no painter_finished expected within 20000 cycles");
    end
  endtask

  task automatic check_frame(input string tag, input int lat);
    bit clr_ok;
    int nd, bad, diff;
    exp_sel = ~exp_sel;
    chk({tag, "_latency"}, lat, frame_cycles());
    chk({tag, "_fb_sel"}, fb_sel, exp_sel);
    clr_ok = (wq_addr.size() >= NPIX);
    for (int i = 0; i < NPIX && clr_ok; i++)
      if (wq_addr[i] != i || wq_data[i] != 1'b0) clr_ok = 1'b0;
    chk({tag, "_clear_ok"}, clr_ok, 1);
    nd = wq_addr.size() - NPIX;
    chk({tag, "_draw_writes"}, nd, exp_addr.size());
    bad = 0;
    if (nd == exp_addr.size())
      for (int i = 0; i < nd; i++)
        if (wq_addr[NPIX+i] != exp_addr[i] || wq_rom[NPIX+i] != exp_rom[i] ||
            wq_data[NPIX+i] != 1'b1) bad++;
    chk({tag, "_draw_seq_bad"}, bad, 0);
    for (int i = 0; i < NPIX; i++) dut_fb[i] = 1'b0;
    diff = 0;
    for (int i = NPIX; i < wq_addr.size(); i++)
      if (wq_addr[i] >= 0 && wq_addr[i] < NPIX) dut_fb[wq_addr[i]] = wq_data[i];
      else diff++;
    for (int i = 0; i < NPIX; i++) if (dut_fb[i] != model_fb[i]) diff++;
    chk({tag, "_image_diff"}, diff, 0);
  endtask

  // ---------------- Directed single-slot vectors ----------------
  typedef struct {
    int sx; int sy; int sw; int sh; int px; int py; int mode;
    int exp_n; int exp_first; int exp_last; int exp_rom_first; int exp_lat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int lat, bad;

    vecs[0] = '{4, 1, 3, 2,  5,  2, 0, 6,  37,  55, 20, 168};
    vecs[1] = '{4, 1, 3, 2, -1,  7, 0, 2, 112, 113, 21, 168};
    vecs[2] = '{4, 1, 0, 5,  5,  2, 0, 0,  -1,  -1, -1, 162};
    vecs[3] = '{0, 0, 4, 4, 14,  6, 0, 4, 110, 127,  0, 178};
    vecs[4] = '{0, 0, 3, 3, -5, -5, 0, 0,  -1,  -1, -1, 171};
    vecs[5] = '{0, 0, 4, 2,  0,  0, 1, 4,   0,  19,  0, 170};

    clear_slots();
    load_slots();

    // Reset values and a long quiet idle period
    do_reset();
    chk("rst_finished", fin, 0);
    chk("rst_fb_sel", fb_sel, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.fb_we !== 1'b0 || fin !== 1'b0 || fb_sel !== 1'b0 || ovr !== 1'b0 ||
          bus.fb_addr !== '0 || bus.fb_data !== 1'b0 || bus.rom_addr !== '0) bad++;
    end
    chk("idle_cycles_bad", bad, 0);

    // Empty render list: clear only
    rom_mode = 0;
    build_model();
    run_frame(-1, lat);
    check_frame("empty", lat);
    chk("empty_latency_abs", lat, 128 + 32 + 1 + 1);
    chk("empty_overrun", ovr, 0);

    // Single-slot table in slot 3
    for (int v = 0; v < 6; v++) begin
      clear_slots();
      slots[3] = '{vecs[v].sx, vecs[v].sy, vecs[v].sw, vecs[v].sh, vecs[v].px, vecs[v].py};
      rom_mode = vecs[v].mode;
      load_slots();
      build_model();
      run_frame(-1, lat);
      check_frame($sformatf("vec%0d", v), lat);
      chk($sformatf("vec%0d_lat_tbl", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d_n_tbl", v), wq_addr.size() - NPIX, vecs[v].exp_n);
      if (vecs[v].exp_n > 0 && wq_addr.size() > NPIX) begin
        chk($sformatf("vec%0d_first", v), wq_addr[NPIX], vecs[v].exp_first);
        chk($sformatf("vec%0d_last", v), wq_addr[wq_addr.size()-1], vecs[v].exp_last);
        chk($sformatf("vec%0d_rom_first", v), wq_rom[NPIX], vecs[v].exp_rom_first);
      end
    end

    // Overlap: slot 2 has no ink, slot 5 inks (4,4) which slot 2 also covers
    clear_slots();
    slots[2] = '{0, 0, 2, 2, 3, 3};
    slots[5] = '{0, 8, 2, 2, 4, 4};
    rom_mode = 3;
    load_slots();
    build_model();
    run_frame(-1, lat);
    check_frame("overlap", lat);
    chk("overlap_n", wq_addr.size() - NPIX, 4);
    chk("overlap_px68", dut_fb[68], 1);

    // Random render lists and random sheet contents
    rom_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4096; i++) rom_mem[i] = 1'($urandom_range(1, 0));
      for (int i = 0; i < RS; i++)
        slots[i] = '{int'($urandom_range(12, 0)), int'($urandom_range(20, 0)),
                     int'($urandom_range(5, 0)), int'($urandom_range(5, 0)),
                     int'($urandom_range(22, 0)) - 4, int'($urandom_range(14, 0)) - 4};
      load_slots();
      build_model();
      run_frame(-1, lat);
      check_frame($sformatf("rand%0d", f), lat);
    end

    // frame_start during CLEAR: ignored, sticky overrun, timing unchanged
    do_reset();
    clear_slots();
    rom_mode = 0;
    load_slots();
    build_model();
    run_frame(10, lat);
    check_frame("midclear", lat);
    chk("midclear_overrun", ovr, 1);

    // frame_start in the DRAIN cycle is ignored; the next cycle is accepted
    do_reset();
    chk("drain_overrun_pre", ovr, 0);
    run_frame(161, lat);
    check_frame("drainpulse", lat);
    chk("drain_overrun", ovr, 1);
    run_frame(-1, lat);
    check_frame("afterdrain", lat);
    chk("afterdrain_fb_sel", fb_sel, 0);

    // Reset during DRAW aborts without a buffer swap
    do_reset();
    clear_slots();
    slots[0] = '{0, 0, 10, 10, 0, 0};
    load_slots();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (140) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_finished", fin, 0);
    chk("abort_fb_sel", fb_sel, 0);
    chk("abort_fb_we", bus.fb_we, 0);
    chk("abort_overrun", ovr, 0);
    any_we = 1'b0;
    repeat (30) tick();
    chk("abort_no_writes", any_we, 0);
    chk("abort_idle_finished", fin, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_painter.md
# sprite_painter

Rasterises the runner's per-frame render list (RENDER_SLOTS sprite/pos pairs) into a double-buffered 1-bpp framebuffer by copying rectangles out of the sprite-sheet ROM. It sits directly downstream of the game-logic block. It raises `painter_finished` when a frame is fully drawn; that rising edge steps the game loop. Slots are drawn in index order, so higher slots overwrite lower ones (z-order).

## Interface
- `RENDER_SLOTS`, 32, number of render slots.
- `FB_W`, 1280, framebuffer width in pixels (GAME_WIDTH×2).
- `FB_H`, 300, framebuffer height in pixels (GAME_HEIGHT×2).
- `SHEET_W`, 2448, sprite-sheet ROM row pitch in pixels.
- `ADDR_W`, 19, width of ROM and framebuffer addresses.

- `clk` in 1: system clock.
- `rst` in 1: reset.
- One clock; reset is synchronous and active-high.
- `frame_start` in 1: one-cycle pulse from the display controller at vsync.
- `sprite` in sprite_t[RENDER_SLOTS]: source rectangle per slot {x,y,w,h}, in sheet pixels.
- `pos` in pos_t[RENDER_SLOTS]: signed destination of the top-left corner, in framebuffer pixels.
- `rom_addr` out ADDR_W: sprite-sheet read address.
- `rom_data` in 1: pixel at the address issued on the previous cycle (1 = ink).
- `fb_we` out 1: framebuffer write strobe.
- `fb_addr` out ADDR_W: framebuffer write address, y*FB_W+x.
- `fb_data` out 1: framebuffer write pixel.
- `fb_sel` out 1: back buffer currently being written. The display scans `!fb_sel`.
- `painter_finished` out 1: high while idle with a completed frame.
- `overrun` out 1: sticky flag, set when a `frame_start` pulse is ignored because the block is busy.

## Operation
- States: IDLE, CLEAR, SETUP, DRAW, DRAIN.
- IDLE + `frame_start`:
  - Snapshot all `sprite`/`pos` into internal registers.
  - Drop `painter_finished` the next cycle.
  - Go to CLEAR.
  - Inputs are not sampled again until the next accepted start.
- `frame_start` in any state other than IDLE: ignored, and `overrun` is set to 1. `overrun` clears only on `rst`.
- CLEAR: writes `fb_data`=0 to addresses 0..FB_W*FB_H−1, one per cycle, then goes to SETUP with slot=0.
- SETUP, one cycle per slot:
  - Load the slot.
  - Compute rom_row_base = y*SHEET_W + x and the destination row base.
  - If w==0 or h==0: advance the slot, or go to DRAIN after the last slot.
  - Otherwise go to DRAW with r=c=0.
- DRAW: one pixel per cycle.
  - Issue `rom_addr` = rom_row_base + c.
  - At end of row (c==w−1): c←0, r←r+1, rom_row_base += SHEET_W, dest row += FB_W.
  - After pixel (w−1,h−1): SETUP for the next slot, or DRAIN after the last slot.
- Address arithmetic: row bases are accumulated; there are no multipliers in the pixel loop. The only multiplies are the slot-base products in SETUP.
- Write stage, one cycle behind DRAW:
  - `fb_we`=1 only if `rom_data`==1 and the destination is in bounds: 0 ≤ pos.x+c < FB_W and 0 ≤ pos.y+r < FB_H, compared signed.
  - `fb_data`=1 on these writes.
  - Transparent (0) pixels and off-screen pixels produce no write.
- The write stage also completes the final pixel of a slot during the following SETUP cycle.
- DRAIN: one cycle that flushes the last pending write. Then:
  - Toggle `fb_sel`.
  - Set `painter_finished`=1.
  - Go to IDLE.

## Timing
- Reset values:
  - state IDLE
  - `painter_finished`=0, `fb_sel`=0, `overrun`=0
  - `fb_we`=0, `fb_addr`=0, `fb_data`=0, `rom_addr`=0
- `rst` mid-frame aborts immediately with the reset values above. No partial buffer swap occurs.
- Frame latency from the accepting `frame_start` edge (cycle 0):
  - CLEAR occupies cycles 1..FB_W*FB_H.
  - Each slot costs 1 + w*h cycles.
  - DRAIN adds 1 cycle.
  - `painter_finished` and the new `fb_sel` are visible the cycle after DRAIN.
- At defaults the worst case must fit in 555,555 clocks (33.33 MHz / 60).
- `frame_start` arriving on the same cycle that DRAIN completes is ignored and sets `overrun`.
- `frame_start` arriving the cycle after DRAIN is accepted.
- `fb_we` is never asserted in IDLE.

## Test plan
- Reset, then no `frame_start` for 100 cycles -> all outputs stay at reset values; `fb_we` never rises.
- FB_W=16, FB_H=8, all slots w=h=0, one `frame_start` -> 128 writes of 0 to addresses 0..127; `painter_finished` rises at cycle 128+32+1+1; `fb_sel`=1.
- Slot 3 = {x=4,y=1,w=3,h=2} at pos (5,2) with an all-ink ROM model (SHEET_W=16) -> rom_addr sequence 20,21,22,36,37,38; writes to fb addresses 37,38,39,53,54,55.
- Same slot at pos (−1,7) -> only (0,7) and (1,7) are written (addresses 112,113); the other 4 pixels are suppressed.
- Slots 2 and 5 overlap at one pixel, and the ROM has ink only for slot 5 -> that pixel is written by slot 5 after slot 2; checkerboard ROM data yields writes only on ink pixels.
- `frame_start` pulsed mid-CLEAR -> ignored, `overrun`=1, frame timing unchanged; `rst` during DRAW -> `painter_finished`=0, `fb_sel` unchanged at 0.
